// File: rtl/seq_divider_64bit.sv
// seq_divider_64bit: iterative restoring divider producing one quotient bit
// per clock. It returns quotient and remainder and flags divide by zero.
// Optional macro SEQ_DIV_SIGNED_EN adds the is_signed input. With it, signed
// operands are converted to magnitudes, and the results get their signs back
// on the final edge.
module seq_divider_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_rem_acc, w_rem_next;
  logic [WIDTH-1:0] r_q_shift, w_q_next;
  logic [WIDTH-1:0] r_divisor, w_div_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic [WIDTH-1:0] r_quotient, w_quot_next;
  logic [WIDTH-1:0] r_remainder, w_remd_next;
  logic             r_error, w_err_next;

  // Operand magnitudes presented to the unsigned core on the accept edge.
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

  // One restoring step. The partial remainder keeps the bit shifted out of
  // rem_acc, so divisors above 2^(WIDTH-1) still divide correctly. The trial
  // difference is formed as A + ~B + 1 with one extra sign bit.
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_neg;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_rem_final;
  logic             w_unused_trial_bit;

  assign w_shifted   = {r_rem_acc, r_q_shift[WIDTH-1]};
  assign w_trial     = {1'b0, w_shifted} + {2'b11, ~r_divisor}
                     + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_trial_neg = w_trial[WIDTH+1];
  // A kept difference is below the divisor, so this bit is always zero.
  assign w_unused_trial_bit = w_trial[WIDTH];
  assign w_rem_step  = w_trial_neg ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_step    = {r_q_shift[WIDTH-2:0], ~w_trial_neg};

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q, w_neg_q_next;
  logic r_neg_r, w_neg_r_next;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg   = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg   = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag   = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag   = w_dvs_neg ? -divisor : divisor;
  // The quotient is negative when the signs differ. The remainder follows
  // the dividend. MIN_INT / -1 gives 2^(WIDTH-1), which negates back to MIN_INT.
  assign w_q_final   = r_neg_q ? -w_q_step : w_q_step;
  assign w_rem_final = r_neg_r ? -w_rem_step : w_rem_step;
`else
  assign w_dvd_mag   = dividend;
  assign w_dvs_mag   = divisor;
  assign w_q_final   = w_q_step;
  assign w_rem_final = w_rem_step;
`endif

  // Next-state and datapath decode: accept, iterate, zero-divide shortcut.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem_acc;
    w_q_next     = r_q_shift;
    w_div_next   = r_divisor;
    w_count_next = r_count;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_quot_next  = r_quotient;
    w_remd_next  = r_remainder;
    w_err_next   = r_error;
`ifdef SEQ_DIV_SIGNED_EN
    w_neg_q_next = r_neg_q;
    w_neg_r_next = r_neg_r;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_busy_next  = 1'b1;
          w_rem_next   = '0;
          w_div_next   = w_dvs_mag;
          w_count_next = CNT_W'(WIDTH);
`ifdef SEQ_DIV_SIGNED_EN
          w_neg_q_next = w_dvd_neg ^ w_dvs_neg;
          w_neg_r_next = w_dvd_neg;
`endif
          if (divisor == '0) begin
            // Keep the untouched dividend; it becomes the remainder.
            w_state_next = S_ZERO;
            w_q_next     = dividend;
          end else begin
            w_state_next = S_RUN;
            w_q_next     = w_dvd_mag;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        w_rem_next   = w_rem_step;
        w_q_next     = w_q_step;
        w_count_next = r_count - CNT_W'(1);
        // The last step retires here, so results land on the same edge.
        if (r_count == CNT_W'(1)) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_quot_next  = w_q_final;
          w_remd_next  = w_rem_final;
          w_err_next   = 1'b0;
        end
      end
      S_ZERO: begin
        w_state_next = S_DONE;
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_quot_next  = '1;
        w_remd_next  = r_q_shift;
        w_err_next   = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem_acc   <= '0;
      r_q_shift   <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_error     <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_rem_acc   <= w_rem_next;
      r_q_shift   <= w_q_next;
      r_divisor   <= w_div_next;
      r_count     <= w_count_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_quotient  <= w_quot_next;
      r_remainder <= w_remd_next;
      r_error     <= w_err_next;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q     <= w_neg_q_next;
      r_neg_r     <= w_neg_r_next;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign error     = r_error;

endmodule

// File: tb/tb_seq_divider_64bit.sv
// Testbench for seq_divider_64bit: directed scenarios plus randomized
// operands compared against plain arithmetic division.
module tb_seq_divider_64bit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
  logic         is_signed;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation and wait (bounded) for done. lat counts clock edges
  // from the accepting edge (lat=1) up to the edge after which done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, error});
    end
    checks++;
    if (quotient !== '0) begin
      failures++;
      $display("FAIL reset_quotient: got %h expected 0", quotient);
    end
    checks++;
    if (remainder !== '0) begin
      failures++;
      $display("FAIL reset_remainder: got %h expected 0", remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 00", {busy, done});
    end
    $display("test_reset: flags=%b q=%h r=%h", {busy, done, error}, quotient, remainder);
  endtask

  task automatic test_basic();
    int lat;
    run_op(64'd100, 64'd7, lat);
    $display("op 100/7: lat=%0d q=%0d r=%0d err=%0b", lat, quotient, remainder, error);
    checks++;
    if (lat !== 65) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 65", lat);
    end
    checks++;
    if (quotient !== 64'd14 || remainder !== 64'd2 || error !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got q=%0d r=%0d e=%0b expected q=14 r=2 e=0",
               quotient, remainder, error);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = '1;
    divisor  = 64'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_accept: got %b expected 1", busy);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    dividend = 64'd5;
    divisor  = 64'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("op ffff.../1 with stray start: lat=%0d q=%h r=%h err=%0b",
             lat, quotient, remainder, error);
    checks++;
    if (lat !== 65) begin
      failures++;
      $display("FAIL ignore_latency: got %0d expected 65", lat);
    end
    checks++;
    if (quotient !== {W{1'b1}} || remainder !== '0 || error !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: got q=%h r=%h e=%0b expected q=all ones r=0 e=0",
               quotient, remainder, error);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || quotient !== {W{1'b1}}) begin
      failures++;
      $display("FAIL done_pulse_width: got done=%b q=%h expected done=0 q=all ones",
               done, quotient);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(64'd5, 64'd0, lat);
    $display("op 5/0: lat=%0d q=%h r=%0d err=%0b", lat, quotient, remainder, error);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL zero_latency: got %0d expected 2", lat);
    end
    checks++;
    if (quotient !== {W{1'b1}} || remainder !== 64'd5 || error !== 1'b1) begin
      failures++;
      $display("FAIL zero_result: got q=%h r=%0d e=%0b expected q=all ones r=5 e=1",
               quotient, remainder, error);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || error !== 1'b1 || remainder !== 64'd5) begin
      failures++;
      $display("FAIL zero_hold: got done=%b e=%b r=%0d expected done=0 e=1 r=5",
               done, error, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    dividend = 64'd9;
    divisor  = 64'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("op 9/3 (start held): lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    checks++;
    if (lat !== 65 || quotient !== 64'd3 || remainder !== 64'd0) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=65 q=3 r=0",
               lat, quotient, remainder);
    end
    dividend = 64'd12;
    divisor  = 64'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reaccept: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("op 12/5 (back-to-back): lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    checks++;
    if (lat !== 65 || quotient !== 64'd2 || remainder !== 64'd2) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=65 q=2 r=2",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, eq, er;
    logic ee;
    int el;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(255, 1));
        2: b = {$urandom, $urandom} | 64'h0000_0001_0000_0000;
        default: b = (i % 8 == 3) ? 64'd0 : {1'b1, 31'($urandom), $urandom};
      endcase
      if (i % 4 == 2) a = a >> 40;
      if (b == 0) begin
        eq = '1;
        er = a;
        ee = 1'b1;
        el = 2;
      end else begin
        eq = a / b;
        er = a % b;
        ee = 1'b0;
        el = 65;
      end
      run_op(a, b, lat);
      $display("op %h/%h: lat=%0d q=%h r=%h err=%0b", a, b, lat, quotient, remainder, error);
      checks++;
      if (lat !== el) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, el);
      end
      checks++;
      if (quotient !== eq) begin
        failures++;
        $display("FAIL rand_quotient[%0d]: got %h expected %h", i, quotient, eq);
      end
      checks++;
      if (remainder !== er) begin
        failures++;
        $display("FAIL rand_remainder[%0d]: got %h expected %h", i, remainder, er);
      end
      checks++;
      if (error !== ee) begin
        failures++;
        $display("FAIL rand_error[%0d]: got %b expected %b", i, error, ee);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int done_seen;
    run_op(64'd77, 64'd5, lat);
    checks++;
    if (quotient !== 64'd15 || remainder !== 64'd2) begin
      failures++;
      $display("FAIL pre_reset_op: got q=%0d r=%0d expected q=15 r=2", quotient, remainder);
    end
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 64'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset mid-run: busy=%b done=%b q=%h r=%h err=%b",
             busy, done, quotient, remainder, error);
    checks++;
    if ({busy, done, error} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got flags=%b q=%h r=%h expected all zero",
               {busy, done, error}, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL midrun_no_done: got %0d done pulses expected 0", done_seen);
    end
    run_op(64'd1000, 64'd3, lat);
    $display("op 1000/3 after reset: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    checks++;
    if (lat !== 65 || quotient !== 64'd333 || remainder !== 64'd1 || error !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op: got lat=%0d q=%0d r=%0d e=%b expected lat=65 q=333 r=1 e=0",
               lat, quotient, remainder, error);
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    int lat;
    longint sa, sb, sq, sr;
    logic [W-1:0] minv;
    minv = {1'b1, {(W-1){1'b0}}};
    is_signed = 1'b1;
    run_op(-64'sd7, 64'sd2, lat);
    $display("signed -7/2: lat=%0d q=%h r=%h err=%0b", lat, quotient, remainder, error);
    checks++;
    if (lat !== 65 || quotient !== -64'sd3 || remainder !== -64'sd1 || error !== 1'b0) begin
      failures++;
      $display("FAIL signed_neg7_2: got lat=%0d q=%h r=%h e=%b expected q=-3 r=-1 e=0",
               lat, quotient, remainder, error);
    end
    run_op(minv, {W{1'b1}}, lat);
    $display("signed MIN/-1: q=%h r=%h err=%0b", quotient, remainder, error);
    checks++;
    if (quotient !== minv || remainder !== '0 || error !== 1'b0) begin
      failures++;
      $display("FAIL signed_min_neg1: got q=%h r=%h e=%b expected q=%h r=0 e=0",
               quotient, remainder, error, minv);
    end
    run_op(-64'sd9, 64'd0, lat);
    checks++;
    if (lat !== 2 || quotient !== {W{1'b1}} || remainder !== -64'sd9 || error !== 1'b1) begin
      failures++;
      $display("FAIL signed_zero: got lat=%0d q=%h r=%h e=%b expected lat=2 r=-9 e=1",
               lat, quotient, remainder, error);
    end
    for (int i = 0; i < 6; i++) begin
      sa = longint'({$urandom, $urandom});
      sb = longint'($signed(32'($urandom))) >>> (i * 4);
      if (sb == 0) sb = -5;
      sq = sa / sb;
      sr = sa % sb;
      run_op(sa, sb, lat);
      $display("signed %0d/%0d: q=%0d r=%0d", sa, sb, $signed(quotient), $signed(remainder));
      checks++;
      if (quotient !== sq || remainder !== sr || lat !== 65) begin
        failures++;
        $display("FAIL signed_rand[%0d]: got q=%h r=%h lat=%0d expected q=%h r=%h lat=65",
                 i, quotient, remainder, lat, sq, sr);
      end
    end
    is_signed = 1'b0;
  endtask
`endif

  initial begin
`ifdef SEQ_DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    test_reset();
    test_basic();
    test_ignore_start();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
